// File: rtl/clock_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_gen
// Purpose  : Multi-channel divided-clock / clock-enable generator. Each channel
//            divides CLOCK by a programmable ratio, waits a programmable start
//            delay, and supports glitch-free gating and run-time ratio change.
//            Gate and ratio updates are applied only at period boundaries.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLOCK      in   1              source clock, rising edge
//   RESET      in   1              synchronous active-high reset
//   CH_EN      in   NUM_CH         per-channel run enable
//   GATE_EN    in   NUM_CH         per-channel gate request (1 = open)
//   DIV_CFG    in   NUM_CH*DIV_W   per-channel ratio, ch i at [i*DIV_W +: DIV_W]
//   PHASE_CFG  in   NUM_CH*DIV_W   per-channel start delay in CLOCK cycles
//   CLK_OUT    out  NUM_CH         gated divided clock
//   TICK       out  NUM_CH         pulse in last cycle of each period (ungated)
//   GATE_STS   out  NUM_CH         applied gate state
//   CFG_CHG    out  NUM_CH         pulse in the first cycle of a new ratio
// ============================================================================
module clock_div_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic [NUM_CH-1:0]       CH_EN,
  input  logic [NUM_CH-1:0]       GATE_EN,
  input  logic [NUM_CH*DIV_W-1:0] DIV_CFG,
  input  logic [NUM_CH*DIV_W-1:0] PHASE_CFG,
  output logic [NUM_CH-1:0]       CLK_OUT,
  output logic [NUM_CH-1:0]       TICK,
  output logic [NUM_CH-1:0]       GATE_STS,
  output logic [NUM_CH-1:0]       CFG_CHG
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] C_MIN_DIV = DIV_W'(2);
  localparam logic [DIV_W-1:0] C_ONE     = DIV_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   dly_q, dly_d;
    logic               gate_q, gate_d;
    logic               chg_d;
    logic               clk_q, tick_q, sts_q, chg_q;
    logic [DIV_W-1:0]   cfg_raw, cfg_div, phase;

    assign cfg_raw = DIV_CFG[i*DIV_W +: DIV_W];
    assign phase   = PHASE_CFG[i*DIV_W +: DIV_W];
    // Ratios 0 and 1 cannot produce a high and a low phase; run them as 2.
    assign cfg_div = (cfg_raw < C_MIN_DIV) ? C_MIN_DIV : cfg_raw;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      dly_d   = dly_q;
      gate_d  = gate_q;
      chg_d   = 1'b0;
      case (state_q)
        ST_OFF: begin
          if (CH_EN[i]) begin
            div_d  = cfg_div;
            gate_d = GATE_EN[i];
            cnt_d  = '0;
            if (phase == '0) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_DELAY;
              dly_d   = phase;
            end
          end
        end
        ST_DELAY: begin
          if (!CH_EN[i]) begin
            state_d = ST_OFF;
          end else if (dly_q == C_ONE) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            dly_d = dly_q - C_ONE;
          end
        end
        ST_RUN: begin
          if (cnt_q == div_q - C_ONE) begin
            // Period boundary: the only point where enable, gate and ratio
            // are allowed to act, so the running period is never cut short.
            cnt_d = '0;
            if (!CH_EN[i]) begin
              state_d = ST_OFF;
            end else begin
              gate_d = GATE_EN[i];
              if (cfg_div != div_q) begin
                div_d = cfg_div;
                chg_d = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
        div_q   <= DIV_W'(DEFAULT_DIV);
        dly_q   <= '0;
        gate_q  <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        sts_q   <= 1'b0;
        chg_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        div_q   <= div_d;
        dly_q   <= dly_d;
        gate_q  <= gate_d;
        // Outputs are registered from next-state so they line up with the
        // cycle the state registers describe.
        clk_q   <= (state_d == ST_RUN) && gate_d &&
                   (cnt_d < (div_d - (div_d >> 1)));
        tick_q  <= (state_d == ST_RUN) && (cnt_d == div_d - C_ONE);
        sts_q   <= (state_d != ST_OFF) && gate_d;
        chg_q   <= chg_d;
      end
    end

    assign CLK_OUT[i]  = clk_q;
    assign TICK[i]     = tick_q;
    assign GATE_STS[i] = sts_q;
    assign CFG_CHG[i]  = chg_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_div_gen
// Purpose  : Self-checking bench for clock_div_gen. A queue-based reference
//            model expands each channel's delay and period into a list of
//            expected per-cycle outputs; directed scenarios also check the
//            literal waveforms.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_div_gen;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int DEF = 2;

  logic              CLOCK = 1'b0;
  logic              RESET;
  logic [NCH-1:0]    CH_EN, GATE_EN;
  logic [NCH*DW-1:0] DIV_CFG, PHASE_CFG;
  logic [NCH-1:0]    CLK_OUT, TICK, GATE_STS, CFG_CHG;

  clock_div_gen #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DEF)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .CH_EN(CH_EN), .GATE_EN(GATE_EN),
    .DIV_CFG(DIV_CFG), .PHASE_CFG(PHASE_CFG), .CLK_OUT(CLK_OUT),
    .TICK(TICK), .GATE_STS(GATE_STS), .CFG_CHG(CFG_CHG)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic clk;
    logic tick;
    logic sts;
    logic chg;
    logic dly;
  } ent_t;

  ent_t mq [NCH][$];
  int   m_div  [NCH];
  logic m_gate [NCH];
  logic [NCH-1:0] e_clk, e_tick, e_sts, e_chg;

  function automatic int clampi(int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic ent_t mk(logic c, logic t, logic s, logic g, logic d);
    ent_t e;
    e.clk = c; e.tick = t; e.sts = s; e.chg = g; e.dly = d;
    return e;
  endfunction

  task automatic push_period(int c, logic chg);
    int d = m_div[c];
    for (int k = 0; k < d; k++)
      mq[c].push_back(mk(m_gate[c] && (k < (d + 1) / 2), k == d - 1,
                         m_gate[c], chg && (k == 0), 1'b0));
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      int   cfg;
      int   ph;
      ent_t e;
      cfg = clampi(int'(DIV_CFG[c*DW +: DW]));
      ph  = int'(PHASE_CFG[c*DW +: DW]);
      if (RESET) begin
        mq[c].delete();
        m_div[c] = DEF;
      end else if (mq[c].size() == 0) begin
        if (CH_EN[c]) begin
          m_div[c]  = cfg;
          m_gate[c] = GATE_EN[c];
          for (int k = 0; k < ph; k++)
            mq[c].push_back(mk(1'b0, 1'b0, m_gate[c], 1'b0, 1'b1));
          push_period(c, 1'b0);
        end
      end else begin
        e = mq[c].pop_front();
        if (e.dly) begin
          if (!CH_EN[c]) mq[c].delete();
        end else if (e.tick) begin
          if (!CH_EN[c]) begin
            mq[c].delete();
          end else begin
            logic chg;
            chg       = (cfg != m_div[c]);
            m_gate[c] = GATE_EN[c];
            m_div[c]  = cfg;
            push_period(c, chg);
          end
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (mq[c].size() > 0) begin
        e_clk[c] = mq[c][0].clk; e_tick[c] = mq[c][0].tick;
        e_sts[c] = mq[c][0].sts; e_chg[c]  = mq[c][0].chg;
      end else begin
        e_clk[c] = 1'b0; e_tick[c] = 1'b0; e_sts[c] = 1'b0; e_chg[c] = 1'b0;
      end
    end
  endtask

  // Advance one clock: model consumes the inputs sampled at this edge, then
  // outputs are observed 1 time unit later.
  task automatic tick_clk();
    @(posedge CLOCK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; CH_EN = '0; GATE_EN = '0; DIV_CFG = '0; PHASE_CFG = '0;
    tick_clk();
    tick_clk();
    RESET = 1'b0;
  endtask

  task automatic set_ch(int c, int div, int ph, logic gate, logic en);
    DIV_CFG[c*DW +: DW]   = DW'(div);
    PHASE_CFG[c*DW +: DW] = DW'(ph);
    GATE_EN[c] = gate;
    CH_EN[c]   = en;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RESET = 1'b1; CH_EN = '1; GATE_EN = '1; DIV_CFG = '1; PHASE_CFG = '0;
    tick_clk();
    checks++;
    if ({CLK_OUT, TICK, GATE_STS, CFG_CHG} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got clk=%b tick=%b sts=%b chg=%b exp all 0",
               CLK_OUT, TICK, GATE_STS, CFG_CHG);
    end
    do_reset();
  endtask

  task automatic test_div4();
    logic ec, et;
    do_reset();
    set_ch(0, 4, 0, 1'b1, 1'b1);
    for (int n = 1; n <= 12; n++) begin
      tick_clk();
      ec = ((n - 1) % 4) < 2;
      et = ((n - 1) % 4) == 3;
      checks++;
      if (CLK_OUT[0] !== ec || TICK[0] !== et) begin
        errors++;
        $display("FAIL div4_pattern n=%0d got clk=%b tick=%b exp clk=%b tick=%b",
                 n, CLK_OUT[0], TICK[0], ec, et);
      end
      checks++;
      if ({CLK_OUT, TICK, GATE_STS, CFG_CHG} !== {e_clk, e_tick, e_sts, e_chg}) begin
        errors++;
        $display("FAIL div4_model n=%0d got %h exp %h", n,
                 {CLK_OUT, TICK, GATE_STS, CFG_CHG}, {e_clk, e_tick, e_sts, e_chg});
      end
    end
  endtask

  task automatic test_phase();
    logic ec;
    do_reset();
    set_ch(0, 5, 3, 1'b1, 1'b1);
    for (int n = 1; n <= 14; n++) begin
      tick_clk();
      ec = (n >= 4) && (((n - 4) % 5) < 3);
      checks++;
      if (CLK_OUT[0] !== ec || GATE_STS[0] !== 1'b1) begin
        errors++;
        $display("FAIL phase5_pattern n=%0d got clk=%b sts=%b exp clk=%b sts=1",
                 n, CLK_OUT[0], GATE_STS[0], ec);
      end
    end
    for (int dv = 0; dv <= 1; dv++) begin
      do_reset();
      set_ch(0, dv, 0, 1'b1, 1'b1);
      for (int n = 1; n <= 6; n++) begin
        tick_clk();
        ec = ((n - 1) % 2) == 0;
        checks++;
        if (CLK_OUT[0] !== ec || TICK[0] !== ~ec) begin
          errors++;
          $display("FAIL div_clamp div=%0d n=%0d got clk=%b tick=%b exp clk=%b tick=%b",
                   dv, n, CLK_OUT[0], TICK[0], ec, ~ec);
        end
      end
    end
  endtask

  task automatic test_div_change();
    logic ec, eg;
    int   pulses = 0;
    do_reset();
    set_ch(0, 4, 0, 1'b1, 1'b1);
    for (int n = 1; n <= 22; n++) begin
      tick_clk();
      if (n == 2) DIV_CFG[0 +: DW] = 8'd6;
      ec = (n <= 2) ? 1'b1 : (n <= 4) ? 1'b0 : (((n - 5) % 6) < 3);
      eg = (n == 5);
      if (CFG_CHG[0]) pulses++;
      checks++;
      if (CLK_OUT[0] !== ec || CFG_CHG[0] !== eg) begin
        errors++;
        $display("FAIL div_change n=%0d got clk=%b chg=%b exp clk=%b chg=%b",
                 n, CLK_OUT[0], CFG_CHG[0], ec, eg);
      end
      checks++;
      if ({CLK_OUT, TICK, GATE_STS, CFG_CHG} !== {e_clk, e_tick, e_sts, e_chg}) begin
        errors++;
        $display("FAIL div_change_model n=%0d got %h exp %h", n,
                 {CLK_OUT, TICK, GATE_STS, CFG_CHG}, {e_clk, e_tick, e_sts, e_chg});
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL cfg_chg_count got %0d exp 1", pulses);
    end
  endtask

  task automatic test_gate();
    logic ec, et, es;
    do_reset();
    set_ch(0, 4, 0, 1'b1, 1'b1);
    for (int n = 1; n <= 20; n++) begin
      tick_clk();
      if (n == 1)  GATE_EN[0] = 1'b0;
      if (n == 10) GATE_EN[0] = 1'b1;
      ec = (n <= 2) ? 1'b1 : (n <= 12) ? 1'b0 : (((n - 1) % 4) < 2);
      et = ((n - 1) % 4) == 3;
      es = (n <= 4) || (n >= 13);
      checks++;
      if (CLK_OUT[0] !== ec || TICK[0] !== et || GATE_STS[0] !== es) begin
        errors++;
        $display("FAIL gate n=%0d got clk=%b tick=%b sts=%b exp clk=%b tick=%b sts=%b",
                 n, CLK_OUT[0], TICK[0], GATE_STS[0], ec, et, es);
      end
    end
  endtask

  task automatic test_ch_disable();
    logic ec, et;
    do_reset();
    set_ch(0, 8, 0, 1'b1, 1'b1);
    for (int n = 1; n <= 12; n++) begin
      tick_clk();
      if (n == 1) CH_EN[0] = 1'b0;
      ec = (n <= 4);
      et = (n == 8);
      checks++;
      if (CLK_OUT[0] !== ec || TICK[0] !== et ||
          GATE_STS[0] !== (n <= 8) || CFG_CHG[0] !== 1'b0) begin
        errors++;
        $display("FAIL ch_disable n=%0d got clk=%b tick=%b sts=%b chg=%b exp clk=%b tick=%b sts=%b chg=0",
                 n, CLK_OUT[0], TICK[0], GATE_STS[0], CFG_CHG[0], ec, et, n <= 8);
      end
    end
    CH_EN[0] = 1'b1;
    tick_clk();
    tick_clk();
    checks++;
    if (CLK_OUT[0] !== 1'b1) begin
      errors++;
      $display("FAIL reenable_high got clk=%b exp 1", CLK_OUT[0]);
    end
    RESET = 1'b1;
    tick_clk();
    RESET = 1'b0;
    checks++;
    if ({CLK_OUT, TICK, GATE_STS, CFG_CHG} !== 16'h0) begin
      errors++;
      $display("FAIL midrun_reset got clk=%b tick=%b sts=%b chg=%b exp all 0",
               CLK_OUT, TICK, GATE_STS, CFG_CHG);
    end
    CH_EN = '0;
  endtask

  task automatic test_random();
    int   dtab [8] = '{0, 1, 2, 3, 4, 5, 7, 9};
    int   init [4] = '{2, 3, 4, 7};
    int   hl [NCH], ll [NCH], lowreq [NCH];
    logic prev [NCH], fell [NCH];
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      set_ch(c, init[c], $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
      hl[c] = 0; ll[c] = 0; lowreq[c] = 0; prev[c] = 1'b0; fell[c] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      tick_clk();
      checks++;
      if ({CLK_OUT, TICK, GATE_STS, CFG_CHG} !== {e_clk, e_tick, e_sts, e_chg}) begin
        errors++;
        $display("FAIL random_model n=%0d got %h exp %h", n,
                 {CLK_OUT, TICK, GATE_STS, CFG_CHG}, {e_clk, e_tick, e_sts, e_chg});
      end
      for (int c = 0; c < NCH; c++) begin
        if (CLK_OUT[c]) begin
          if (!prev[c] && fell[c]) begin
            checks++;
            if (ll[c] < lowreq[c]) begin
              errors++;
              $display("FAIL low_run ch=%0d got %0d exp >=%0d", c, ll[c], lowreq[c]);
            end
          end
          hl[c]++;
          ll[c] = 0;
        end else begin
          if (prev[c]) begin
            checks++;
            if (hl[c] != (m_div[c] + 1) / 2) begin
              errors++;
              $display("FAIL high_run ch=%0d got %0d exp %0d", c, hl[c], (m_div[c] + 1) / 2);
            end
            lowreq[c] = m_div[c] / 2;
            fell[c]   = 1'b1;
          end
          ll[c]++;
          hl[c] = 0;
        end
        prev[c] = CLK_OUT[c];
      end
      if ($urandom_range(0, 7) == 0) begin
        int c = $urandom_range(0, NCH - 1);
        GATE_EN[c] = ~GATE_EN[c];
      end
      if ($urandom_range(0, 15) == 0) begin
        int c = $urandom_range(0, NCH - 1);
        DIV_CFG[c*DW +: DW] = DW'(dtab[$urandom_range(0, 7)]);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_div[c] = DEF;
      m_gate[c] = 1'b0;
    end
    RESET = 1'b1; CH_EN = '0; GATE_EN = '0; DIV_CFG = '0; PHASE_CFG = '0;
    test_reset();
    test_div4();
    test_phase();
    test_div_change();
    test_gate();
    test_ch_disable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_div_gen.md
Name: clock_div_gen

Overview:
- Synthesizable multi-channel clock-enable/divided-clock generator. Successor to the bench-only single clock source.
- Derives NUM_CH divided clocks from one CLOCK. Each channel has a programmable divide ratio, a start-phase delay, glitch-free gating and glitch-free run-time frequency change.
- Sits at the top of the DUT-side clocking so ALU sub-blocks and bench monitors get the same per-channel TICK/CLK_OUT timing.

Parameters:
- NUM_CH, 4, number of independent channels.
- DIV_W, 8, width of each divide-ratio and phase field; max ratio 2^DIV_W-1.
- DEFAULT_DIV, 2, active ratio loaded into every channel at reset.

Ports:
- CLOCK  input  1  single source clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- CH_EN  input  NUM_CH  per-channel run enable.
- GATE_EN  input  NUM_CH  per-channel output gate request; 1 = open.
- DIV_CFG  input  NUM_CH*DIV_W  per-channel divide ratio; channel i at [i*DIV_W +: DIV_W].
- PHASE_CFG  input  NUM_CH*DIV_W  per-channel start delay in CLOCK cycles; same packing.
- CLK_OUT  output  NUM_CH  divided clock, gated.
- TICK  output  NUM_CH  one-cycle pulse in the last cycle of each period; not gated.
- GATE_STS  output  NUM_CH  current applied gate state.
- CFG_CHG  output  NUM_CH  one-cycle pulse when a new ratio takes effect.

Behaviour:
- One clock, synchronous active-high reset. All outputs are driven directly from flops.
- RESET sampled high: every channel goes to OFF with active_div=DEFAULT_DIV and cnt=0. All outputs are 0 from the next cycle. This applies mid-operation too, with no partial pulse completed.
- Ratio clamp: a DIV_CFG value below 2 is treated as 2. PHASE_CFG is not clamped.
- Per-channel FSM has three states: OFF, DELAY, RUN.
- OFF:
  - Outputs 0, GATE_STS 0.
  - When CH_EN=1 is sampled: active_div <= clamp(DIV_CFG) and gate_open <= GATE_EN.
  - If PHASE_CFG=0, go to RUN at period cycle 0. Otherwise go to DELAY with dly <= PHASE_CFG.
  - The first RUN cycle is therefore 1+PHASE_CFG cycles after the CH_EN sample.
- DELAY:
  - Outputs 0. dly decrements each cycle; when dly=1, go to RUN at period cycle 0.
  - CH_EN=0 sampled in DELAY: go to OFF next cycle.
- RUN, with period of D=active_div cycles numbered 0..D-1:
  - Raw clock is high in cycles 0..ceil(D/2)-1 and low for the remaining floor(D/2) cycles.
  - CLK_OUT = raw & gate_open. TICK=1 in cycle D-1 only.
- Period boundary (cycle D-1 -> cycle 0): all of the following inputs are sampled only in cycle D-1.
  - GATE_EN is copied into gate_open, which takes effect from cycle 0. Raw is low in cycle D-1, so opening or closing the gate never creates a runt pulse.
  - If clamp(DIV_CFG) != active_div, the new value is used from cycle 0 and CFG_CHG=1 for that cycle 0. The current period is never truncated.
  - If CH_EN=0, go to OFF next cycle instead of cycle 0, and apply no DIV/GATE updates.
- Simultaneous events at the same boundary: CH_EN=0 wins. Otherwise the gate update and ratio update apply together.
- GATE_STS = gate_open while in RUN or DELAY.
- Channels are fully independent; there is no shared state besides CLOCK and RESET.
- Counter width is DIV_W; cnt never exceeds active_div-1, so there is no wrap beyond the period.

Test Plan:
- Reset, then CH_EN[0]=1, DIV=4, PHASE=0, GATE=1 -> CLK_OUT[0] pattern 1100 repeating starting 1 cycle after the enable sample; TICK[0] high on every 4th cycle, aligned with the last 0.
- DIV=5, PHASE=3 -> first CLK_OUT high 4 cycles after the enable sample; pattern 11100; DIV=0 and DIV=1 both give 10 repeating.
- Change DIV 4->6 mid-period -> current period completes as 1100; CFG_CHG pulses once at the first 111000 period; no other CFG_CHG pulses.
- Drop GATE_EN while CLK_OUT is high, with DIV=4 -> the current high pulse stays full width; CLK_OUT stays 0 from the next period; TICK continues; GATE_STS falls at the period start. Re-raise -> CLK_OUT resumes at a period start.
- Drop CH_EN in period cycle 1 with DIV=8 -> the period completes (4 high, 4 low), then the channel goes OFF with all outputs 0. Assert RESET mid-high-phase -> all outputs 0 the next cycle.
- Four channels with DIV 2/3/4/7, random GATE_EN and DIV_CFG toggling -> the checker sees no CLK_OUT high run shorter than ceil(D/2) and no low run shorter than floor(D/2) of the applied ratio; channels are independent.
